// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched
// -----------------
// Iterative AES-128 inverse key schedule for the decryption datapath.
// Starting from the round-10 key, it walks backwards one round per cycle and
// presents round keys 10, 9, ..., 0 on a valid/ready interface. Only the
// current round key is stored. The previous key is derived combinationally
// from it.
//
// Optional build macro: FWD_KEY_INPUT_EN
//   When it is defined, key_in is the round-0 cipher key. An accepted load first
//   spends 10 cycles in EXPAND, running the forward expansion up to round 10,
//   and then starts emitting keys. Load-to-first-valid latency is then 11
//   cycles instead of 1.
//
// Ports
//   clk       in   1    system clock; all state updates on the rising edge
//   rst       in   1    synchronous active-high reset
//   load      in   1    start request; sampled only while busy=0
//   key_in    in   128  round-10 key (round-0 key with FWD_KEY_INPUT_EN);
//                       word 0 = key_in[127:96]
//   rk_out    out  128  current round key; word 0 = rk_out[127:96]
//   rk_round  out  4    round index of rk_out (10 down to 0)
//   rk_valid  out  1    rk_out/rk_round valid
//   rk_ready  in   1    consumer accepts rk_out
//   busy      out  1    accepted load until the round-0 handshake completes
//   done      out  1    one-cycle pulse after the round-0 handshake
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EMIT   = 2'd1;
`ifdef FWD_KEY_INPUT_EN
  localparam logic [1:0] ST_EXPAND = 2'd2;
`endif

  // The forward AES S-box is stored row-major with entry 0x00 in the MSBs.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x starts at bit (255 - x) * 8. That equals {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] rot;
    rot = {w[23:0], w[31:24]};
    return {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  endfunction

  // Rcon is indexed by the round being stepped back from.
  function automatic logic [7:0] inv_rcon(input logic [3:0] r);
    case (r)
      4'd10:   return 8'h36;
      4'd9:    return 8'h1b;
      4'd8:    return 8'h80;
      4'd7:    return 8'h40;
      4'd6:    return 8'h20;
      4'd5:    return 8'h10;
      4'd4:    return 8'h08;
      4'd3:    return 8'h04;
      4'd2:    return 8'h02;
      4'd1:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one forward expansion step: recover round r-1 from round r.
  function automatic logic [127:0] prev_key(input logic [127:0] k,
                                            input logic [3:0]   r);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_rot_word(p3) ^ {inv_rcon(r), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

`ifdef FWD_KEY_INPUT_EN
  function automatic logic [7:0] fwd_rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One forward step: produce round i from round i-1.
  function automatic logic [127:0] next_key(input logic [127:0] k,
                                            input logic [3:0]   i);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {fwd_rcon(i), 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction
`endif

  logic [1:0]   r_state;
  logic [127:0] r_rk_out;
  logic [3:0]   r_rk_round;
  logic         r_rk_valid;
  logic         r_busy;
  logic         r_done;
`ifdef FWD_KEY_INPUT_EN
  logic [3:0]   r_exp_cnt;
  logic [127:0] w_next_key;
`endif

  logic [127:0] w_prev_key;
  logic         w_hs;

  assign w_prev_key = prev_key(r_rk_out, r_rk_round);
  assign w_hs       = r_rk_valid & rk_ready;
`ifdef FWD_KEY_INPUT_EN
  assign w_next_key = next_key(r_rk_out, r_exp_cnt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rk_out   <= '0;
      r_rk_round <= '0;
      r_rk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef FWD_KEY_INPUT_EN
      r_exp_cnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_busy   <= 1'b1;
            r_rk_out <= key_in;
`ifdef FWD_KEY_INPUT_EN
            // rk_out doubles as the expansion working register while rk_valid is low.
            r_exp_cnt <= 4'd1;
            r_state   <= ST_EXPAND;
`else
            r_rk_round <= LAST_RND;
            r_rk_valid <= 1'b1;
            r_state    <= ST_EMIT;
`endif
          end
        end
        ST_EMIT: begin
          // Without a handshake, everything holds. This is the stall case.
          if (w_hs) begin
            if (r_rk_round == 4'd0) begin
              // The last key has been consumed. rk_out/rk_round stay as they are.
              r_rk_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_rk_out   <= w_prev_key;
              r_rk_round <= r_rk_round - 4'd1;
            end
          end
        end
`ifdef FWD_KEY_INPUT_EN
        ST_EXPAND: begin
          r_rk_out  <= w_next_key;
          r_exp_cnt <= r_exp_cnt + 4'd1;
          if (r_exp_cnt == LAST_RND) begin
            r_rk_round <= LAST_RND;
            r_rk_valid <= 1'b1;
            r_state    <= ST_EMIT;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rk_out   = r_rk_out;
  assign rk_round = r_rk_round;
  assign rk_valid = r_rk_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
